// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
//   clk    - pipeline clock, rising edge
//   reset  - asynchronous active-low reset
//   md_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   rs_e   - operand A, also the mthi/mtlo source
//   rt_e   - operand B
//   rd_sel - md_out select: 0 LO, 1 HI
//   busy   - multiply/divide in progress
//   hi, lo - architectural HI/LO registers
//   md_out - rd_sel ? hi : lo
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    logic [CW-1:0] cnt;
    logic [63:0]   pending, prod, result;
    logic          pend_wr, is_mul, is_div, sx, a_neg, b_neg, dz;
    logic [31:0]   ua, ub, uq, ur;
    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of relying on simulator/synthesis overflow behaviour.
    always_comb begin
        is_mul = md_op == 3'd1 || md_op == 3'd2;
        is_div = md_op == 3'd3 || md_op == 3'd4;
        sx     = md_op == 3'd1 || md_op == 3'd3;
        a_neg  = sx & rs_e[31];
        b_neg  = sx & rt_e[31];
        dz     = rt_e == 32'd0;
        prod   = {{32{a_neg}}, rs_e} * {{32{b_neg}}, rt_e};
        ua     = a_neg ? -rs_e : rs_e;
        ub     = dz ? 32'd1 : b_neg ? -rt_e : rt_e;
        uq     = ua / ub;
        ur     = ua % ub;
        result = is_mul ? prod : {a_neg ? -ur : ur, (a_neg ^ b_neg) ? -uq : uq};
        md_out = rd_sel ? hi : lo;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            pending <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
                if (pend_wr) {hi, lo} <= pending;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (is_mul || is_div) begin
            busy    <= 1'b1;
            cnt     <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            pending <= result;
            pend_wr <= !(is_div && dz);
        end else if (md_op == 3'd5) begin
            hi <= rs_e;
        end else if (md_op == 3'd6) begin
            lo <= rs_e;
        end
    end
endmodule
